// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the starship fault logic: state encodings,
// room indices and the 16-bit Galois LFSR used for random choices.
package nexys_starship_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      RUN  = 3'b010,
      OVER = 3'b100
   } state_e;

   localparam int ROOM_TOP   = 0;
   localparam int ROOM_BTM   = 1;
   localparam int ROOM_LEFT  = 2;
   localparam int ROOM_RIGHT = 3;

   // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit LFSR; seed reloaded on reset. A maximal-length
// sequence from a non-zero seed never reaches the all-zero lock-up state.
module nexys_starship_lfsr16
   import nexys_starship_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   output logic [15:0] lfsr_q
);

   // Advance one step every non-reset cycle
   always_ff @(posedge Clk) begin
      if (Reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_step(lfsr_q);
   end

endmodule

// File: rtl/nexys_starship_fault_dispatcher.sv
// Schedules break events to the room FSMs on a shrinking interval,
// choosing a healthy room from an LFSR candidate, and declares game over
// when any room stays broken too long.
module nexys_starship_fault_dispatcher
   import nexys_starship_pkg::*;
#(
   parameter int          NUM_ROOMS      = 4,
   parameter logic [31:0] INIT_INTERVAL  = 32'd200_000_000,
   parameter logic [31:0] MIN_INTERVAL   = 32'd50_000_000,
   parameter logic [31:0] INTERVAL_STEP  = 32'd10_000_000,
   parameter logic [31:0] BROKEN_TIMEOUT = 32'd1_000_000_000
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 play_flag,
   input  logic [NUM_ROOMS-1:0] room_broken,
   output logic [NUM_ROOMS-1:0] room_random,
   output logic [3:0]           random_hex,
   output logic                 gameover_ctrl,
   output logic [7:0]           fault_count,
   output logic                 q_Idle,
   output logic                 q_Run,
   output logic                 q_Over
);

   localparam int RW = (NUM_ROOMS > 1) ? $clog2(NUM_ROOMS) : 1;

   state_e                     state_q, state_d;
   logic [31:0]                cnt_q, cnt_d, cur_q, cur_d, cur_dec;
   logic [NUM_ROOMS-1:0][31:0] tmr_q, tmr_d;
   logic [NUM_ROOMS-1:0]       rr_q, rr_d, pick_oh;
   logic [3:0]                 hex_q, hex_d;
   logic [7:0]                 fc_q, fc_d;
   logic [15:0]                lfsr;
   logic                       timeout, expire;
   logic [RW-1:0]              idx;
   int                         cand;

   nexys_starship_lfsr16 u_lfsr (
      .Clk    (Clk),
      .Reset  (Reset),
      .lfsr_q (lfsr)
   );

   // First healthy room scanning cyclically from the LFSR candidate;
   // iterating backwards lets the nearest healthy room win.
   always_comb begin
      pick_oh = '0;
      idx     = '0;
      cand    = int'(lfsr[1:0]) % NUM_ROOMS;
      for (int k = NUM_ROOMS - 1; k >= 0; k--) begin
         idx = RW'((cand + k) % NUM_ROOMS);
         if (!room_broken[idx]) begin
            pick_oh      = '0;
            pick_oh[idx] = 1'b1;
         end
      end
   end

   // A room broken now whose timer already holds TIMEOUT-1 reaches the limit
   always_comb begin
      timeout = 1'b0;
      for (int i = 0; i < NUM_ROOMS; i++)
         if (room_broken[i] && (tmr_q[i] >= BROKEN_TIMEOUT - 32'd1)) timeout = 1'b1;
   end

   // Shrink the interval without wrapping below the floor
   assign cur_dec = ((cur_q >= INTERVAL_STEP) && ((cur_q - INTERVAL_STEP) > MIN_INTERVAL))
                    ? (cur_q - INTERVAL_STEP) : MIN_INTERVAL;
   // Counter reaching zero on this edge means a dispatch attempt now
   assign expire  = (cnt_q <= 32'd1);

   // Next-state, scheduling, timers and dispatch
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      tmr_d   = tmr_q;
      rr_d    = '0;
      hex_d   = hex_q;
      fc_d    = fc_q;
      case (state_q)
         IDLE: begin
            cnt_d = INIT_INTERVAL;
            cur_d = INIT_INTERVAL;
            tmr_d = '0;
            if (play_flag) begin
               state_d = RUN;
               fc_d    = 8'd0;
            end
         end
         RUN: begin
            for (int i = 0; i < NUM_ROOMS; i++)
               tmr_d[i] = room_broken[i] ? tmr_q[i] + 32'd1 : 32'd0;
            cnt_d = cnt_q - 32'd1;
            if (timeout) begin
               // Timeout beats both a pending dispatch and a play drop
               state_d = OVER;
            end else if (!play_flag) begin
               state_d = IDLE;
            end else if (expire) begin
               cnt_d = cur_q;
               if (|pick_oh) begin
                  rr_d  = pick_oh;
                  hex_d = lfsr[7:4];
                  fc_d  = (fc_q == 8'hFF) ? fc_q : fc_q + 8'd1;
                  cur_d = cur_dec;
                  cnt_d = cur_dec;
               end
            end
         end
         OVER: begin
            tmr_d = '0;
            if (!play_flag) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= INIT_INTERVAL;
         cur_q   <= INIT_INTERVAL;
         tmr_q   <= '0;
         rr_q    <= '0;
         hex_q   <= 4'd0;
         fc_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         tmr_q   <= tmr_d;
         rr_q    <= rr_d;
         hex_q   <= hex_d;
         fc_q    <= fc_d;
      end
   end

   assign room_random   = rr_q;
   assign random_hex    = hex_q;
   assign fault_count   = fc_q;
   assign gameover_ctrl = (state_q == OVER);
   assign q_Idle        = (state_q == IDLE);
   assign q_Run         = (state_q == RUN);
   assign q_Over        = (state_q == OVER);

endmodule

// File: doc/nexys_starship_fault_dispatcher.md
Name: nexys_starship_fault_dispatcher

Overview:
Issues the break events that the per-room repair FSMs consume.
- Each room FSM takes a one-cycle `<room>_random` pulse plus a 4-bit `random_hex` repair code, and reports its broken flag back.
- This block schedules faults on a shrinking interval and picks a healthy room pseudo-randomly.
- It tracks how long each room stays broken and asserts `gameover_ctrl` when any room exceeds its timeout.
- It sits between the top-level play control and the room FSMs.

Parameters:
- NUM_ROOMS, 4, number of rooms (index 0 = top, 1 = bottom, 2 = left, 3 = right).
- INIT_INTERVAL, 32'd200_000_000, cycles between faults at game start.
- MIN_INTERVAL, 32'd50_000_000, interval floor; must be >= 2.
- INTERVAL_STEP, 32'd10_000_000, interval decrement after each dispatch.
- BROKEN_TIMEOUT, 32'd1_000_000_000, maximum consecutive broken cycles per room before game over.

Ports:
- Clk, input, 1, system clock.
- Reset, input, 1, synchronous active-high reset.
- play_flag, input, 1, game running request.
- room_broken, input, NUM_ROOMS, broken flags returned by the room FSMs.
- room_random, output, NUM_ROOMS, one-hot one-cycle break pulse, one bit per room.
- random_hex, output, 4, repair code; valid in the pulse cycle and held until the next dispatch.
- gameover_ctrl, output, 1, level; high while in OVER.
- fault_count, output, 8, faults dispatched this game, saturating.
- q_Idle, q_Run, q_Over, output, 1 each, one-hot state.

Behaviour:
- One clock; reset is synchronous and active-high.
- Ports are named Clk and Reset.
- All registers update only on posedge Clk.
- Reset values:
  - state = IDLE
  - room_random = 0
  - random_hex = 0
  - gameover_ctrl = 0
  - fault_count = 0
  - LFSR = 16'hACE1
  - interval counter = INIT_INTERVAL
  - cur_interval = INIT_INTERVAL
  - all broken timers = 0
- Reset mid-game behaves identically to power-up: any pulse in flight is dropped.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Steps every non-reset cycle in every state.
  - Must never reach 0.
- IDLE:
  - Outputs 0; timers cleared; cur_interval and counter = INIT_INTERVAL.
  - play_flag = 1 -> RUN, clearing fault_count on that edge.
- RUN, interval counter:
  - Decrements every cycle.
  - At 0 it performs a dispatch attempt and reloads with cur_interval.
- RUN, dispatch attempt:
  - Candidate index c = LFSR[1:0] mod NUM_ROOMS.
  - Select the first room with room_broken = 0, scanning c, c+1, ... cyclically.
  - If all rooms are broken, no pulse; counter still reloads.
  - On success, in the same registered cycle:
    - room_random[sel] = 1 for exactly one cycle
    - random_hex = LFSR[7:4]
    - fault_count += 1, saturating at 255
    - cur_interval = max(cur_interval − INTERVAL_STEP, MIN_INTERVAL), with no underflow
- Timing contract:
  - Room FSMs raise room_broken one cycle after the pulse.
  - MIN_INTERVAL >= 2 guarantees no double-dispatch to the same room.
- Broken timers, one per room, active only in RUN:
  - Increment while room_broken[i] = 1; clear to 0 when it is 0.
  - When any timer reaches BROKEN_TIMEOUT -> OVER.
- RUN exits:
  - play_flag = 0 -> IDLE, with no gameover.
  - Timeout and play_flag = 0 in the same cycle -> OVER (timeout wins).
  - Timeout and dispatch in the same cycle -> OVER; no pulse issued.
- OVER:
  - gameover_ctrl = 1; room_random = 0; fault_count frozen for score display.
  - play_flag = 0 -> IDLE.
- Undefined state -> IDLE.

Decomposition:
- Shared package nexys_starship_pkg:
  - state encodings IDLE = 3'b001, RUN = 3'b010, OVER = 3'b100
  - room index constants ROOM_TOP, ROOM_BTM, ROOM_LEFT, ROOM_RIGHT
  - LFSR_SEED = 16'hACE1 and the tap mask
- Sub-module nexys_starship_lfsr16:
  - ports Clk, Reset, lfsr_q[15:0]
  - free-running, seed loaded on reset
  - reusable by other random consumers

Test Plan:
Bench parameters: INIT_INTERVAL = 10, STEP = 2, MIN_INTERVAL = 4, BROKEN_TIMEOUT = 50, room model echoes the pulse into room_broken one cycle later.
- Reset, then play_flag = 1 at cycle 0 -> first room_random pulse 10 cycles after RUN entry; random_hex = LFSR[7:4] of that cycle; fault_count = 1.
- Keep rooms repaired immediately -> gaps between pulses are 8, 6, 4, 4, 4; the interval never goes below 4.
- Force room_broken = 4'b0111 with candidate 1 -> pulse goes to room 3; with room_broken = 4'b1111 -> no pulse, counter reloads.
- Leave one room broken for 50 cycles -> OVER, gameover_ctrl = 1, fault_count frozen; play_flag = 0 -> IDLE next cycle, gameover_ctrl = 0.
- Timer hits 50 on the same cycle the counter expires -> OVER with room_random = 0.
- Assert Reset in the pulse cycle -> next cycle room_random = 0, state IDLE, LFSR = 16'hACE1; play_flag = 0 in RUN -> IDLE with gameover_ctrl held 0.
